// File: rtl/coef_ram_pingpong.sv
// Banked, multi-channel FIR coefficient store with ping-pong pages.
// The filter reads the active page; the host writes and reads back the shadow page, which swaps in on a frame boundary.
module coef_ram_pingpong #(
  parameter int NCH    = 2,
  parameter int NBANKS = 4,
  parameter int DW     = 36,
  parameter int DEPTH  = 4096,
  parameter int AW     = $clog2(DEPTH),
  parameter int HAW    = $clog2(NCH) + AW + $clog2(NBANKS)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [HAW-1:0]           host_addr,
  input  logic [DW-1:0]            host_wdata,
  input  logic                     host_we,
  input  logic                     host_re,
  input  logic                     host_psel,
  output logic [DW-1:0]            host_rdata,
  output logic                     host_rvalid,
  input  logic [NCH*AW-1:0]        app_addr,
  input  logic                     app_en,
  output logic [NCH*NBANKS*DW-1:0] coef,
  output logic                     coef_valid,
  input  logic                     frame_start,
  input  logic                     swap_req,
  input  logic                     clear_req,
  output logic                     busy,
  output logic                     swap_done,
  output logic                     clear_done,
  output logic                     active_page
);

  localparam int CW = $clog2(NCH);
  localparam int BW = $clog2(NBANKS);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PEND  = 2'd1;
  localparam logic [1:0] CLEAR = 2'd2;

  logic [1:0]              stateReg;
  logic                    activePageReg;
  logic [AW-1:0]           clearCntReg;
  logic                    swapDoneReg;
  logic                    clearDoneReg;
  logic [NCH*NBANKS*DW-1:0] coefReg;
  logic [NCH*NBANKS*DW-1:0] coefNext;
  logic                    coefValidReg;
  logic [DW-1:0]           hostRdataReg;
  logic                    hostRvalidReg;

  logic [CW-1:0]           hostCh;
  logic [AW-1:0]           hostWord;
  logic [BW-1:0]           hostBank;
  logic                    hostPage;
  logic                    hostWrite;
  logic                    hostRead;
  logic                    clearing;

  logic [DW-1:0]           appWord    [2][NCH][NBANKS];
  logic [DW-1:0]           hostRdWord [2][NCH][NBANKS];

  assign hostBank = host_addr[BW-1:0];
  assign hostWord = host_addr[BW +: AW];
  assign hostCh   = host_addr[BW+AW +: CW];
  assign hostPage = host_psel ? ~activePageReg : activePageReg;

  // A host write wins over a simultaneous read; the clear sequencer owns the shadow page outright.
  assign hostWrite = reset && host_we && (stateReg != CLEAR);
  assign hostRead  = host_re && !host_we && (stateReg != CLEAR);
  assign clearing  = reset && (stateReg == CLEAR);

  for (genvar gp = 0; gp < 2; gp++) begin : gPage
    for (genvar gc = 0; gc < NCH; gc++) begin : gChan
      for (genvar gi = 0; gi < NBANKS; gi++) begin : gBank
        logic [DW-1:0] mem [DEPTH];
        logic          isShadow;
        logic          wrEn;
        logic [AW-1:0] wrAddr;
        logic [DW-1:0] wrData;

        assign isShadow = (activePageReg != 1'(gp));
        assign wrEn     = isShadow &&
                          (clearing || (hostWrite && hostCh == CW'(gc) && hostBank == BW'(gi)));
        assign wrAddr   = clearing ? clearCntReg : hostWord;
        assign wrData   = clearing ? '0 : host_wdata;

        always_ff @(posedge clock) begin
          if (wrEn) begin
            mem[wrAddr] <= wrData;
          end
        end

        assign appWord[gp][gc][gi]    = mem[app_addr[gc*AW +: AW]];
        assign hostRdWord[gp][gc][gi] = mem[hostWord];
      end
    end
  end

  // Bank 0 lands in the most significant field of each channel's slice.
  always_comb begin
    coefNext = '0;
    for (int c = 0; c < NCH; c++) begin
      for (int b = 0; b < NBANKS; b++) begin
        coefNext[(c*NBANKS + (NBANKS-1-b))*DW +: DW] = appWord[activePageReg][c][b];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      coefReg      <= '0;
      coefValidReg <= 1'b0;
    end else begin
      coefValidReg <= app_en;
      if (app_en) begin
        coefReg <= coefNext;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      hostRdataReg  <= '0;
      hostRvalidReg <= 1'b0;
    end else begin
      hostRvalidReg <= hostRead;
      if (hostRead) begin
        hostRdataReg <= hostRdWord[hostPage][hostCh][hostBank];
      end
    end
  end

  // Requests arriving outside IDLE are dropped, not queued.
  always_ff @(posedge clock) begin
    if (!reset) begin
      stateReg      <= IDLE;
      activePageReg <= 1'b0;
      clearCntReg   <= '0;
      swapDoneReg   <= 1'b0;
      clearDoneReg  <= 1'b0;
    end else begin
      swapDoneReg  <= 1'b0;
      clearDoneReg <= 1'b0;
      case (stateReg)
        IDLE: begin
          if (swap_req) begin
            stateReg <= PEND;
          end else if (clear_req) begin
            stateReg    <= CLEAR;
            clearCntReg <= '0;
          end
        end
        PEND: begin
          if (frame_start) begin
            activePageReg <= ~activePageReg;
            swapDoneReg   <= 1'b1;
            stateReg      <= IDLE;
          end
        end
        CLEAR: begin
          clearCntReg <= clearCntReg + 1'b1;
          if (clearCntReg == AW'(DEPTH-1)) begin
            stateReg     <= IDLE;
            clearDoneReg <= 1'b1;
          end
        end
        default: stateReg <= IDLE;
      endcase
    end
  end

  assign coef        = coefReg;
  assign coef_valid  = coefValidReg;
  assign host_rdata  = hostRdataReg;
  assign host_rvalid = hostRvalidReg;
  assign busy        = (stateReg != IDLE);
  assign swap_done   = swapDoneReg;
  assign clear_done  = clearDoneReg;
  assign active_page = activePageReg;

endmodule
